// File: rtl/eligibility_time_gate.sv
// Eligibility-time gate: buffers descriptors and releases the head once the reference
// timer reaches its eligibility time, discarding heads that are later than a threshold.
module eligibility_time_gate #(
    parameter int                          TIMESTAMP_WIDTH   = 72,
    parameter int                          DESC_WIDTH        = 64,
    parameter int                          FIFO_DEPTH_LOG2   = 3,
    parameter logic [TIMESTAMP_WIDTH-1:0]  LATE_THRESHOLD_PS = '0
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [TIMESTAMP_WIDTH-1:0]  reference_timer_input,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DESC_WIDTH-1:0]       s_data,
    input  logic [TIMESTAMP_WIDTH-1:0]  s_eligibility_time,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DESC_WIDTH-1:0]       m_data,
    output logic [TIMESTAMP_WIDTH-1:0]  m_eligibility_time,
    output logic [FIFO_DEPTH_LOG2:0]    fifo_level,
    output logic [31:0]                 drop_count
);
    localparam int TW    = TIMESTAMP_WIDTH;
    localparam int DW    = DESC_WIDTH;
    localparam int L     = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << L;
    localparam logic [L:0] FULL_LEVEL = DEPTH[L:0];

    typedef enum logic [1:0] {IDLE, CHECK, HOLD} state_t;

    state_t          state_reg;
    logic [TW+DW-1:0] mem [DEPTH];
    logic [L-1:0]    wr_ptr_reg;
    logic [L-1:0]    rd_ptr_reg;
    logic [L:0]      level_reg;
    logic [L:0]      level_next;
    logic            ready_reg;
    logic            m_valid_reg;
    logic [DW-1:0]   m_data_reg;
    logic [TW-1:0]   m_elig_reg;
    logic [31:0]     drop_count_reg;

    logic            push;
    logic            pop;
    logic [TW-1:0]   head_elig;
    logic [DW-1:0]   head_data;
    logic [TW-1:0]   diff;
    logic            head_eligible;
    logic            head_late;

    // Head is read asynchronously: it must be evaluated the cycle after it is written.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= {s_eligibility_time, s_data};
    end

    assign head_elig = mem[rd_ptr_reg][TW+DW-1:DW];
    assign head_data = mem[rd_ptr_reg][DW-1:0];

    // Modular difference keeps the comparison correct across timer wrap.
    assign diff          = reference_timer_input - head_elig;
    assign head_eligible = ~diff[TW-1];
    assign head_late     = head_eligible && (LATE_THRESHOLD_PS != '0) && (diff > LATE_THRESHOLD_PS);

    assign push = s_valid && s_ready;
    assign pop  = (state_reg == CHECK) && (level_reg != '0) && head_eligible;

    always_comb begin
        level_next = level_reg;
        if (push && !pop)
            level_next = level_reg + (L+1)'(1);
        else if (!push && pop)
            level_next = level_reg - (L+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            level_reg      <= '0;
            ready_reg      <= 1'b0;
            m_valid_reg    <= 1'b0;
            m_data_reg     <= '0;
            m_elig_reg     <= '0;
            drop_count_reg <= '0;
        end else begin
            level_reg <= level_next;
            ready_reg <= (level_next != FULL_LEVEL);
            if (push)
                wr_ptr_reg <= wr_ptr_reg + L'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + L'(1);

            case (state_reg)
                IDLE: begin
                    if (push)
                        state_reg <= CHECK;
                end
                CHECK: begin
                    if (level_reg == '0) begin
                        state_reg <= IDLE;
                    end else if (head_late) begin
                        if (drop_count_reg != '1)
                            drop_count_reg <= drop_count_reg + 32'd1;
                        state_reg <= (level_next != '0) ? CHECK : IDLE;
                    end else if (head_eligible) begin
                        m_valid_reg <= 1'b1;
                        m_data_reg  <= head_data;
                        m_elig_reg  <= head_elig;
                        state_reg   <= HOLD;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid_reg <= 1'b0;
                        state_reg   <= (level_next != '0) ? CHECK : IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign s_ready            = ready_reg;
    assign m_valid            = m_valid_reg;
    assign m_data             = m_data_reg;
    assign m_eligibility_time = m_elig_reg;
    assign fifo_level         = level_reg;
    assign drop_count         = drop_count_reg;
endmodule

// File: tb/tb_eligibility_time_gate.sv
// Scoreboard bench for eligibility_time_gate: expected descriptors are queued on push
// and compared at each output handshake.
module tb_eligibility_time_gate;
    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [71:0]  ref_time = 72'd8000;
    logic [71:0]  ref_step = 72'd0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [63:0]  s_data = '0;
    logic [71:0]  s_eligibility_time = '0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [63:0]  m_data;
    logic [71:0]  m_eligibility_time;
    logic [3:0]   fifo_level;
    logic [31:0]  drop_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [135:0] exp_q[$];

    eligibility_time_gate #(
        .TIMESTAMP_WIDTH  (72),
        .DESC_WIDTH       (64),
        .FIFO_DEPTH_LOG2  (3),
        .LATE_THRESHOLD_PS(72'd16000)
    ) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .reference_timer_input(ref_time),
        .s_valid              (s_valid),
        .s_ready              (s_ready),
        .s_data               (s_data),
        .s_eligibility_time   (s_eligibility_time),
        .m_valid              (m_valid),
        .m_ready              (m_ready),
        .m_data               (m_data),
        .m_eligibility_time   (m_eligibility_time),
        .fifo_level           (fifo_level),
        .drop_count           (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Handshake completes at the next rising edge; sample mid-cycle.
    always @(negedge clk) begin
        if (rstn && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {m_eligibility_time, m_data}, '0);
            end else begin
                logic [135:0] e;
                e = exp_q.pop_front();
                $display("xfer data=%h elig=%0d", m_data, m_eligibility_time);
                check("out_desc", {m_eligibility_time, m_data}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ref_time = ref_time + ref_step;
    endtask

    task automatic push_desc(input logic [63:0] d, input logic [71:0] e, input bit expect_out);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data = d;
        s_eligibility_time = e;
        while (!s_ready && n < 200) begin
            tick();
            n++;
        end
        check("push_ready", s_ready, 1);
        if (expect_out)
            exp_q.push_back({e, d});
        tick();
        s_valid = 1'b0;
    endtask

    task automatic accept_one(input string tag);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check(tag, m_valid, 0);
    endtask

    // Expected m_valid each cycle: eligible if the previous cycle's reference was at
    // or up to half the timer range past the eligibility time.
    task automatic wait_release(input logic [71:0] e, input string tag);
        logic [71:0] prev;
        logic [71:0] half_range;
        bit exp_v;
        half_range = {1'b1, 71'b0};
        for (int n = 0; n < 40; n++) begin
            prev = ref_time;
            tick();
            exp_v = (prev >= e) && (prev < e + half_range);
            check(tag, m_valid, exp_v);
            if (m_valid)
                break;
        end
    endtask

    initial begin
        logic [63:0] held_data;
        logic [71:0] held_elig;

        // Reset state
        tick();
        tick();
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_drops", drop_count, 0);
        rstn = 1'b1;
        tick();
        check("post_rst_s_ready", s_ready, 1);

        // 1: immediate release, two-cycle latency
        push_desc(64'hA1A1_0000_0000_0001, 72'd0, 1);
        check("t1_lat1", m_valid, 0);
        tick();
        check("t1_lat2", m_valid, 1);
        check("t1_data", m_data, 64'hA1A1_0000_0000_0001);
        accept_one("t1_after_accept");

        // 2: held until the reference reaches the eligibility time
        ref_step = 72'd8000;
        push_desc(64'hB2B2_0000_0000_0002, 72'd80000, 1);
        wait_release(72'd80000, "t2_mvalid");
        check("t2_elig", m_eligibility_time, 72'd80000);
        accept_one("t2_after_accept");

        // 3: eligibility time beyond the timer wrap
        ref_time = 72'd0 - 72'd16000;
        push_desc(64'hC3C3_0000_0000_0003, 72'd8000, 1);
        wait_release(72'd8000, "t3_mvalid");
        check("t3_drops", drop_count, 0);
        accept_one("t3_after_accept");

        // 4: late head dropped, next head evaluated the following cycle
        ref_step = 72'd0;
        ref_time = 72'd40000;
        push_desc(64'hD4D4_0000_0000_0004, 72'd0, 0);
        push_desc(64'hE5E5_0000_0000_0005, 72'd40000, 1);
        check("t4_drops", drop_count, 1);
        check("t4_no_valid", m_valid, 0);
        tick();
        check("t4_next_valid", m_valid, 1);
        accept_one("t4_after_accept");
        // Lateness exactly equal to the threshold is not a drop
        push_desc(64'hF6F6_0000_0000_0006, 72'd24000, 1);
        tick();
        check("t4_edge_valid", m_valid, 1);
        check("t4_edge_drops", drop_count, 1);
        accept_one("t4_edge_after_accept");

        // 5: fill with output stalled, extra push stalls, then drain in order
        for (int i = 0; i < 9; i++)
            push_desc(64'h5000 + 64'(i), 72'd40000, 1);
        check("t5_level_full", fifo_level, 8);
        check("t5_s_ready_low", s_ready, 0);
        check("t5_holding", m_valid, 1);
        held_data = m_data;
        held_elig = m_eligibility_time;
        s_valid = 1'b1;
        s_data = 64'h5009;
        s_eligibility_time = 72'd40000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_stall_ready", s_ready, 0);
            check("t5_stall_level", fifo_level, 8);
            check("t5_stable_data", m_data, held_data);
            check("t5_stable_elig", m_eligibility_time, held_elig);
        end
        m_ready = 1'b1;
        push_desc(64'h5009, 72'd40000, 1);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++)
            tick();
        check("t5_drained", exp_q.size(), 0);
        m_ready = 1'b0;
        tick();
        check("t5_level_empty", fifo_level, 0);

        // 6: reset while holding with three queued
        for (int i = 0; i < 4; i++)
            push_desc(64'h6000 + 64'(i), 72'd40000, 1);
        check("t6_level3", fifo_level, 3);
        check("t6_hold", m_valid, 1);
        rstn = 1'b0;
        exp_q.delete();
        tick();
        check("t6_m_valid", m_valid, 0);
        check("t6_level", fifo_level, 0);
        check("t6_drops", drop_count, 0);
        check("t6_s_ready", s_ready, 0);
        rstn = 1'b1;
        tick();
        check("t6_s_ready_back", s_ready, 1);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_flushed", m_valid, 0);
        end
        push_desc(64'h7777_0000_0000_0007, 72'd40000, 1);
        tick();
        tick();
        check("t6_post_drained", exp_q.size(), 0);
        m_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
